// File: rtl/fetch_decode_ctrl.sv
// fetch_decode_ctrl
// -----------------------------------------------------------------------------
// Multi-cycle controller for the 8-bit accumulator datapath. It sits right
// after the IR/PC registers, watches the opcode field IR[7:5], and drives every
// load enable and mux select in the datapath. Each instruction runs as
// FETCH -> DECODE -> one EXECUTE state. IN waits for the user's enter
// handshake. HALT is a sink that only reset can leave.
//
// Ports
//    clock        system clock, rising edge
//    reset        asynchronous active-high reset, forces START
//    IR           opcode bits IR[7:5]
//    Aeq0         accumulator is zero
//    Apos         accumulator is strictly positive (signed)
//    enter        user input-valid handshake
//    IRload       IR register load enable
//    PCload       PC register load enable
//    JMPmux       PC source select (0 = PC+1, 1 = IR[4:0])
//    Meminst      memory address select (1 = PC, 0 = IR[4:0])
//    MemWr        memory write strobe
//    Asel         accumulator source (00 ALU, 01 input, 10 memory)
//    Aload        accumulator load enable
//    Sub          ALU subtract select
//    Halt         high while halted
//    state        current state code, for debug
//    instr_count  retired-instruction counter (only with CTRL_INSTR_COUNT_EN)
//
// Optional feature macro: CTRL_INSTR_COUNT_EN
//    When defined, the 8-bit instr_count output and its counter are added.
// -----------------------------------------------------------------------------
module fetch_decode_ctrl #(
   parameter int OP_WIDTH    = 3,
   parameter int STATE_WIDTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [OP_WIDTH-1:0]    IR,
   input  logic                   Aeq0,
   input  logic                   Apos,
   input  logic                   enter,
   output logic                   IRload,
   output logic                   PCload,
   output logic                   JMPmux,
   output logic                   Meminst,
   output logic                   MemWr,
   output logic [1:0]             Asel,
   output logic                   Aload,
   output logic                   Sub,
   output logic                   Halt,
`ifdef CTRL_INSTR_COUNT_EN
   output logic [STATE_WIDTH-1:0] state,
   output logic [7:0]             instr_count
`else
   output logic [STATE_WIDTH-1:0] state
`endif
);

   // The EXECUTE codes are 8 + opcode. This lets the debug port be read
   // directly as "which instruction is executing".
   typedef enum logic [STATE_WIDTH-1:0] {
      sStart = STATE_WIDTH'(0),
      sFetch = STATE_WIDTH'(1),
      sDecode = STATE_WIDTH'(2),
      sLoad = STATE_WIDTH'(8),
      sStore = STATE_WIDTH'(9),
      sAdd = STATE_WIDTH'(10),
      sSub = STATE_WIDTH'(11),
      sIn = STATE_WIDTH'(12),
      sJz = STATE_WIDTH'(13),
      sJpos = STATE_WIDTH'(14),
      sHalt = STATE_WIDTH'(15)
   } ctrlState_t;

   ctrlState_t stateReg;
   ctrlState_t nextState;

   // State register. Reset takes effect immediately, so the controller
   // abandons any instruction it is running.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stateReg <= sStart;
      end else begin
         stateReg <= nextState;
      end
   end

   // Next-state logic and output decode. Outputs depend only on the state,
   // except for three gating terms: enter gates Aload in IN, Aeq0 gates
   // PCload in JZ, and Apos gates PCload in JPOS. This means the branch
   // decision and the input capture happen in the same single cycle. An
   // unknown opcode sends the controller to HALT rather than running garbage.
   // Any unused state code falls back to START with all outputs off.
   always_comb begin
      nextState = sStart;
      IRload    = 1'b0;
      PCload    = 1'b0;
      JMPmux    = 1'b0;
      Meminst   = 1'b0;
      MemWr     = 1'b0;
      Asel      = 2'b00;
      Aload     = 1'b0;
      Sub       = 1'b0;
      Halt      = 1'b0;
      case (stateReg)
         sStart: begin
            nextState = sFetch;
         end
         sFetch: begin
            IRload    = 1'b1;
            PCload    = 1'b1;
            Meminst   = 1'b1;
            nextState = sDecode;
         end
         sDecode: begin
            case (IR)
               OP_WIDTH'(0): nextState = sLoad;
               OP_WIDTH'(1): nextState = sStore;
               OP_WIDTH'(2): nextState = sAdd;
               OP_WIDTH'(3): nextState = sSub;
               OP_WIDTH'(4): nextState = sIn;
               OP_WIDTH'(5): nextState = sJz;
               OP_WIDTH'(6): nextState = sJpos;
               default:      nextState = sHalt;
            endcase
         end
         sLoad: begin
            Asel      = 2'b10;
            Aload     = 1'b1;
            nextState = sFetch;
         end
         sStore: begin
            MemWr     = 1'b1;
            nextState = sFetch;
         end
         sAdd: begin
            Aload     = 1'b1;
            nextState = sFetch;
         end
         sSub: begin
            Sub       = 1'b1;
            Aload     = 1'b1;
            nextState = sFetch;
         end
         sIn: begin
            Asel      = 2'b01;
            Aload     = enter;
            nextState = enter ? sFetch : sIn;
         end
         sJz: begin
            JMPmux    = 1'b1;
            PCload    = Aeq0;
            nextState = sFetch;
         end
         sJpos: begin
            JMPmux    = 1'b1;
            PCload    = Apos;
            nextState = sFetch;
         end
         sHalt: begin
            Halt      = 1'b1;
            nextState = sHalt;
         end
         default: begin
            nextState = sStart;
         end
      endcase
   end

   assign state = stateReg;

`ifdef CTRL_INSTR_COUNT_EN
   logic execExit;

   // An instruction retires on the edge that leaves its EXECUTE state.
   // IN retires only when enter is high. HALT never retires.
   always_comb begin
      execExit = 1'b0;
      case (stateReg)
         sLoad, sStore, sAdd, sSub, sJz, sJpos: execExit = 1'b1;
         sIn:                                   execExit = enter;
         default:                               execExit = 1'b0;
      endcase
   end

   // Retired-instruction counter. It wraps naturally at 8 bits.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         instr_count <= 8'd0;
      end else if (execExit) begin
         instr_count <= instr_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// tb_fetch_decode_ctrl
// -----------------------------------------------------------------------------
// Self-checking bench for fetch_decode_ctrl.
// - A vector table walks every instruction type and its corner cases.
// - Hand-written sequences cover HALT hold, asynchronous reset and counter wrap.
// - A randomized run is compared against an instruction-level reference model.
// Inputs change 1 time unit after each rising edge. Outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_decode_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic [2:0] IR;
   logic       Aeq0, Apos, enter;
   logic       IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Halt;
   logic [1:0] Asel;
   logic [3:0] state;
`ifdef CTRL_INSTR_COUNT_EN
   logic [7:0] instr_count;
`endif

   logic [9:0] dutOut;
   int         total = 0;
   int         bad = 0;

   // Reference model: current state code and retired-instruction count
   int         modelState;
   logic [7:0] modelCount;

   fetch_decode_ctrl #(.OP_WIDTH(3), .STATE_WIDTH(4)) dut (
      .clock(clock), .reset(reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos),
      .enter(enter), .IRload(IRload), .PCload(PCload), .JMPmux(JMPmux),
      .Meminst(Meminst), .MemWr(MemWr), .Asel(Asel), .Aload(Aload),
      .Sub(Sub), .Halt(Halt),
`ifdef CTRL_INSTR_COUNT_EN
      .state(state), .instr_count(instr_count)
`else
      .state(state)
`endif
   );

   always #5 clock = ~clock;

   assign dutOut = {IRload, PCload, JMPmux, Meminst, MemWr, Asel, Aload, Sub, Halt};

   // Instruction-level model. After DECODE the executing code is
   // 8 + opcode. IN waits on enter. HALT only leaves on reset.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         modelState <= 0;
         modelCount <= 8'd0;
      end else begin
         if ((modelState >= 8 && modelState <= 14 && modelState != 12) ||
             (modelState == 12 && enter))
            modelCount <= modelCount + 8'd1;
         if (modelState == 0)
            modelState <= 1;
         else if (modelState == 1)
            modelState <= 2;
         else if (modelState == 2)
            modelState <= 8 + int'(IR);
         else if (modelState == 12)
            modelState <= enter ? 1 : 12;
         else if (modelState == 15)
            modelState <= 15;
         else
            modelState <= 1;
      end
   end

   // Expected control bundle for a state code and the live flag inputs
   function automatic logic [9:0] expOut(input int c, input logic a, input logic p, input logic e);
      logic [1:0] asel;
      asel = (c == 8) ? 2'b10 : (c == 12) ? 2'b01 : 2'b00;
      return {c == 1,
              (c == 1) || (c == 13 && a) || (c == 14 && p),
              (c == 13) || (c == 14),
              c == 1,
              c == 9,
              asel,
              (c == 8) || (c == 10) || (c == 11) || (c == 12 && e),
              c == 11,
              c == 15};
   endfunction

   typedef struct {
      logic [2:0] ir;
      logic       a, p, e;
      logic [3:0] st;
      logic [9:0] out;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [2:0] ir, input logic a, input logic p,
                               input logic e, input logic [3:0] st, input logic [9:0] out);
      vec_t v;
      v.ir = ir; v.a = a; v.p = p; v.e = e; v.st = st; v.out = out;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] ir, input logic a, input logic p, input logic e);
      IR = ir; Aeq0 = a; Apos = p; enter = e;
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, "State"}, 32'(state), 32'(modelState));
      checkOutput({tag, "Out"}, 32'(dutOut), 32'(expOut(modelState, Aeq0, Apos, enter)));
`ifdef CTRL_INSTR_COUNT_EN
      checkOutput({tag, "Count"}, 32'(instr_count), 32'(modelCount));
`endif
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   localparam logic [9:0] O_NONE  = 10'b0000000000;
   localparam logic [9:0] O_FETCH = 10'b1101000000;
   localparam logic [9:0] O_LOAD  = 10'b0000010100;
   localparam logic [9:0] O_STORE = 10'b0000100000;
   localparam logic [9:0] O_ADD   = 10'b0000000100;
   localparam logic [9:0] O_SUB   = 10'b0000000110;
   localparam logic [9:0] O_IN0   = 10'b0000001000;
   localparam logic [9:0] O_IN1   = 10'b0000001100;
   localparam logic [9:0] O_JT    = 10'b0110000000;
   localparam logic [9:0] O_JF    = 10'b0010000000;
   localparam logic [9:0] O_HALT  = 10'b0000000001;

   initial begin
      // Vector table: one record per cycle, starting in START after reset
      tbl.push_back(mk(3'd0, 0, 0, 0, 4'd0,  O_NONE));
      tbl.push_back(mk(3'd0, 0, 0, 0, 4'd1,  O_FETCH));
      tbl.push_back(mk(3'd0, 0, 0, 0, 4'd2,  O_NONE));
      tbl.push_back(mk(3'd0, 0, 0, 0, 4'd8,  O_LOAD));
      tbl.push_back(mk(3'd4, 0, 0, 0, 4'd1,  O_FETCH));
      tbl.push_back(mk(3'd4, 0, 0, 0, 4'd2,  O_NONE));
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(3'd4, 0, 0, 0, 4'd12, O_IN0));
      tbl.push_back(mk(3'd4, 0, 0, 1, 4'd12, O_IN1));
      tbl.push_back(mk(3'd5, 1, 0, 1, 4'd1,  O_FETCH));
      tbl.push_back(mk(3'd5, 1, 0, 1, 4'd2,  O_NONE));
      tbl.push_back(mk(3'd5, 1, 0, 0, 4'd13, O_JT));
      tbl.push_back(mk(3'd5, 0, 0, 0, 4'd1,  O_FETCH));
      tbl.push_back(mk(3'd5, 0, 0, 0, 4'd2,  O_NONE));
      tbl.push_back(mk(3'd5, 0, 0, 0, 4'd13, O_JF));
      tbl.push_back(mk(3'd6, 0, 0, 0, 4'd1,  O_FETCH));
      tbl.push_back(mk(3'd6, 0, 0, 0, 4'd2,  O_NONE));
      tbl.push_back(mk(3'd6, 0, 0, 0, 4'd14, O_JF));
      tbl.push_back(mk(3'd6, 0, 1, 0, 4'd1,  O_FETCH));
      tbl.push_back(mk(3'd6, 0, 1, 0, 4'd2,  O_NONE));
      tbl.push_back(mk(3'd6, 0, 1, 0, 4'd14, O_JT));
      tbl.push_back(mk(3'd3, 0, 0, 0, 4'd1,  O_FETCH));
      tbl.push_back(mk(3'd3, 0, 0, 0, 4'd2,  O_NONE));
      tbl.push_back(mk(3'd3, 0, 0, 0, 4'd11, O_SUB));
      tbl.push_back(mk(3'd1, 0, 0, 0, 4'd1,  O_FETCH));
      tbl.push_back(mk(3'd1, 0, 0, 0, 4'd2,  O_NONE));
      tbl.push_back(mk(3'd1, 0, 0, 0, 4'd9,  O_STORE));
      tbl.push_back(mk(3'd2, 0, 0, 0, 4'd1,  O_FETCH));
      tbl.push_back(mk(3'd2, 0, 0, 0, 4'd2,  O_NONE));
      tbl.push_back(mk(3'd2, 0, 0, 0, 4'd10, O_ADD));
      tbl.push_back(mk(3'd7, 0, 0, 0, 4'd1,  O_FETCH));
      tbl.push_back(mk(3'd7, 0, 0, 0, 4'd2,  O_NONE));
      tbl.push_back(mk(3'd7, 0, 0, 0, 4'd15, O_HALT));

      reset = 1'b1;
      applyStimulus(3'd0, 0, 0, 0);
      tick();
      @(negedge clock);
      checkOutput("resetState", 32'(state), 32'd0);
      checkOutput("resetOut", 32'(dutOut), 32'd0);
      tick();
      reset = 1'b0;

      // Table-driven walk through all instruction types
      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i].ir, tbl[i].a, tbl[i].p, tbl[i].e);
         @(negedge clock);
         checkOutput($sformatf("tblState%0d", i), 32'(state), 32'(tbl[i].st));
         checkOutput($sformatf("tblOut%0d", i), 32'(dutOut), 32'(tbl[i].out));
         tick();
      end
`ifdef CTRL_INSTR_COUNT_EN
      checkOutput("tblCount", 32'(instr_count), 32'd9);
`endif

      // HALT must hold regardless of inputs
      for (int i = 0; i < 20; i++) begin
         applyStimulus(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom));
         @(negedge clock);
         checkOutput("haltHold", {27'd0, state, Halt}, {27'd0, 4'd15, 1'b1});
         tick();
      end

      // Asynchronous reset in the middle of a cycle acts before the next edge
      #2 reset = 1'b1;
      #1;
      checkOutput("asyncRstState", 32'(state), 32'd0);
      checkOutput("asyncRstOut", 32'(dutOut), 32'd0);
`ifdef CTRL_INSTR_COUNT_EN
      checkOutput("asyncRstCount", 32'(instr_count), 32'd0);
`endif
      tick();
      reset = 1'b0;

      // Randomized run against the reference model
      for (int i = 0; i < 3000; i++) begin
         if (modelState == 15 && $urandom_range(0, 3) == 0) begin
            reset = 1'b1;
            @(negedge clock);
            checkOutput("rndResetOut", 32'(dutOut), 32'd0);
            tick();
            reset = 1'b0;
         end else begin
            applyStimulus(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                          $urandom_range(0, 2) == 0);
            @(negedge clock);
            checkModel("rnd");
            tick();
         end
      end

`ifdef CTRL_INSTR_COUNT_EN
      // 256 ADD instructions wrap the counter back to zero
      reset = 1'b1;
      tick();
      reset = 1'b0;
      applyStimulus(3'd2, 0, 0, 0);
      begin
         int done;
         done = 0;
         while (done < 256) begin
            @(negedge clock);
            checkModel("wrap");
            if (modelState == 10) done++;
            tick();
         end
      end
      @(negedge clock);
      checkOutput("wrapCount", 32'(instr_count), 32'd0);
      checkOutput("wrapState", 32'(state), 32'd1);
      tick();
      tick();
      tick();
      tick();
      @(negedge clock);
      checkOutput("preRstCount", 32'(instr_count), 32'd1);
      checkOutput("preRstState", 32'(state), 32'd2);
      #2 reset = 1'b1;
      #1;
      checkOutput("decRstCount", 32'(instr_count), 32'd0);
      checkOutput("decRstState", 32'(state), 32'd0);
      tick();
      reset = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
